// File: rtl/rle_flash_fetch.sv
// rle_flash_fetch
//   QSPI flash fetch controller that streams 16-bit RLE words to the RLE video
//   decoder. A small prefetch FIFO keeps data ahead of the decoder. The decoder
//   consumes words with a read_next/data_ready handshake. stop_data aborts the
//   stream. The consumer address can be cleared, saved and reloaded so that a
//   frame can be restarted or repeated.
//
//   Flash protocol: Quad Output Fast Read (0x6B). The command and a 24-bit
//   address go out on d0. Eight dummy periods follow, then nibbles on d[3:0].
//   One bit period is two clk cycles: sck is low, then high. Outputs change
//   when sck falls. spi_d_in is sampled on the clk edge where sck falls.
//
// Parameters
//   BASE_ADDR   byte address used by reset and clear_addr
//   END_ADDR    last word address before wrapping (only with RLE_FETCH_WRAP_EN)
//   FIFO_DEPTH  number of prefetched words held (2..4)
//   CS_HIGH     minimum clk cycles spi_cs_n stays high between transactions
//
// Configuration macro
//   RLE_FETCH_WRAP_EN  when defined, the fetch stream wraps from END_ADDR back
//                      to BASE_ADDR by starting a new transaction. The consumer
//                      address wraps the same way. When undefined, the read is
//                      one linear stream that wraps only at 2^24.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   read_next                 consume the head word (ignored while data_ready=0)
//   stop_data                 abort stream, flush FIFO, stay idle while high
//   data_ready, data[15:0]    FIFO non-empty flag and FIFO head word
//   save_addr                 saved_addr <= next unconsumed word address
//   load_addr                 cur_addr <= saved_addr, flush, restart
//   clear_addr                cur_addr <= BASE_ADDR, flush, restart
//   spi_cs_n, spi_sck         flash chip select and clock (clk/2)
//   spi_d_out, spi_d_oe       flash data out and per-bit output enables
//   spi_d_in                  flash data in
module rle_flash_fetch #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter logic [23:0] END_ADDR   = 24'hFFFFFE,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CS_HIGH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read_next,
    input  logic        stop_data,
    output logic        data_ready,
    output logic [15:0] data,
    input  logic        save_addr,
    input  logic        load_addr,
    input  logic        clear_addr,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic [3:0]  spi_d_out,
    output logic [3:0]  spi_d_oe,
    input  logic [3:0]  spi_d_in
);

    localparam logic [7:0]  CMD_QREAD = 8'h6B;
    localparam logic [23:0] BASE_W    = {BASE_ADDR[23:1], 1'b0};

    typedef enum logic [2:0] {S_GAP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IDLE} state_t;

    state_t      state;
    logic [7:0]  gap_cnt;
    logic        ph;           // 0: sck-low half of the bit period, 1: sck-high half
    logic [4:0]  bit_cnt;
    logic [1:0]  nib_cnt;
    logic [23:0] shreg;        // bits still to be sent after the one on d0
    logic [11:0] word_sh;
    logic        land_vld;     // completed word waiting one clk to enter the FIFO
    logic [15:0] land_data;
    logic [23:0] fetch_addr;   // address of the word being fetched or fetched next
    logic [23:0] cur_addr;
    logic [23:0] saved_addr;

    logic [15:0] mem [0:3];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;

    logic        flush;
    logic        pop;
    logic [2:0]  occ;
    logic        slot_free;
    logic [23:0] cur_step;
    logic [23:0] cur_nxt;
    logic [23:0] unconsumed;
    logic        fetch_last;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign flush      = stop_data | load_addr | clear_addr;
    assign data_ready = (count != 3'd0);
    assign data       = mem[rd_ptr];
    assign pop        = read_next && data_ready;
    // A landed word already owns a slot, so it is counted as occupied.
    assign occ        = count + {2'b00, land_vld};
    assign slot_free  = (occ < 3'(FIFO_DEPTH));

`ifdef RLE_FETCH_WRAP_EN
    localparam logic [23:0] END_W = {END_ADDR[23:1], 1'b0};
    assign cur_step   = (cur_addr == END_W) ? BASE_W : cur_addr + 24'd2;
    assign fetch_last = (fetch_addr == END_W);
`else
    logic unused_end_addr;
    assign unused_end_addr = ^END_ADDR;
    assign cur_step   = cur_addr + 24'd2;
    assign fetch_last = 1'b0;
`endif

    // clear_addr has priority over load_addr. A pop only moves the address
    // when no address op happens in the same clk.
    always_comb begin
        cur_nxt = cur_addr;
        if (clear_addr)
            cur_nxt = BASE_W;
        else if (load_addr)
            cur_nxt = saved_addr;
        else if (pop)
            cur_nxt = cur_step;
    end

    assign unconsumed = pop ? cur_step : cur_addr;

    // Consumer address tracking. A load reads the old saved_addr.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_addr   <= BASE_W;
            saved_addr <= BASE_W;
        end else begin
            cur_addr <= cur_nxt;
            if (save_addr)
                saved_addr <= unconsumed;
        end
    end

    // Prefetch FIFO control
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (land_vld)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + {2'b00, land_vld} - {2'b00, pop};
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (land_vld)
            mem[wr_ptr] <= land_data;
    end

    // Transaction FSM with registered flash pins
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_GAP;
            gap_cnt    <= 8'd0;
            ph         <= 1'b0;
            bit_cnt    <= 5'd0;
            nib_cnt    <= 2'd0;
            land_vld   <= 1'b0;
            fetch_addr <= BASE_W;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_d_out  <= 4'd0;
            spi_d_oe   <= 4'd0;
        end else if (flush) begin
            state      <= stop_data ? S_IDLE : S_GAP;
            gap_cnt    <= 8'd0;
            ph         <= 1'b0;
            nib_cnt    <= 2'd0;
            land_vld   <= 1'b0;
            fetch_addr <= cur_nxt;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_d_out  <= 4'd0;
            spi_d_oe   <= 4'd0;
        end else begin
            land_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    state   <= S_GAP;
                    gap_cnt <= 8'd0;
                end
                S_GAP: begin
                    if (gap_cnt >= 8'(CS_HIGH - 1)) begin
                        state     <= S_CMD;
                        spi_cs_n  <= 1'b0;
                        ph        <= 1'b0;
                        bit_cnt   <= 5'd0;
                        shreg     <= {CMD_QREAD[6:0], 17'd0};
                        spi_d_out <= {3'b000, CMD_QREAD[7]};
                        spi_d_oe  <= 4'b0001;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    if (!ph) begin
                        // Hold sck low at a word boundary until the word has a slot.
                        if (state != S_DATA || nib_cnt != 2'd0 || slot_free) begin
                            spi_sck <= 1'b1;
                            ph      <= 1'b1;
                        end
                    end else begin
                        spi_sck <= 1'b0;
                        ph      <= 1'b0;
                        case (state)
                            S_CMD: begin
                                if (bit_cnt == 5'd7) begin
                                    state     <= S_ADDR;
                                    bit_cnt   <= 5'd0;
                                    shreg     <= {fetch_addr[22:0], 1'b0};
                                    spi_d_out <= {3'b000, fetch_addr[23]};
                                end else begin
                                    bit_cnt   <= bit_cnt + 5'd1;
                                    shreg     <= {shreg[22:0], 1'b0};
                                    spi_d_out <= {3'b000, shreg[23]};
                                end
                            end
                            S_ADDR: begin
                                if (bit_cnt == 5'd23) begin
                                    state     <= S_DUMMY;
                                    bit_cnt   <= 5'd0;
                                    spi_d_out <= 4'd0;
                                    spi_d_oe  <= 4'd0;
                                end else begin
                                    bit_cnt   <= bit_cnt + 5'd1;
                                    shreg     <= {shreg[22:0], 1'b0};
                                    spi_d_out <= {3'b000, shreg[23]};
                                end
                            end
                            S_DUMMY: begin
                                if (bit_cnt == 5'd7) begin
                                    state   <= S_DATA;
                                    nib_cnt <= 2'd0;
                                end else begin
                                    bit_cnt <= bit_cnt + 5'd1;
                                end
                            end
                            S_DATA: begin
                                word_sh <= {word_sh[7:0], spi_d_in};
                                if (nib_cnt == 2'd3) begin
                                    land_vld  <= 1'b1;
                                    land_data <= {word_sh, spi_d_in};
                                    nib_cnt   <= 2'd0;
                                    if (fetch_last) begin
                                        // End of window: restart at BASE and keep the FIFO.
                                        fetch_addr <= BASE_W;
                                        state      <= S_GAP;
                                        gap_cnt    <= 8'd0;
                                        spi_cs_n   <= 1'b1;
                                    end else begin
                                        fetch_addr <= fetch_addr + 24'd2;
                                    end
                                end else begin
                                    nib_cnt <= nib_cnt + 2'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_flash_fetch.sv
// Testbench for rle_flash_fetch: behavioural QSPI flash, address-level
// reference model of the consumer stream, table-driven address-op steps,
// directed corner sequences and randomized traffic.
module tb_rle_flash_fetch;

    localparam logic [23:0] BASE = 24'h000000;
`ifdef RLE_FETCH_WRAP_EN
    localparam logic [23:0] ENDA = 24'h000006;
`else
    localparam logic [23:0] ENDA = 24'hFFFFFE;
`endif

    logic        clk;
    logic        rstn;
    logic        read_next;
    logic        stop_data;
    logic        data_ready;
    logic [15:0] data;
    logic        save_addr;
    logic        load_addr;
    logic        clear_addr;
    logic        spi_cs_n;
    logic        spi_sck;
    logic [3:0]  spi_d_out;
    logic [3:0]  spi_d_oe;
    logic [3:0]  spi_d_in;

    rle_flash_fetch #(
        .BASE_ADDR (BASE),
        .END_ADDR  (ENDA),
        .FIFO_DEPTH(2),
        .CS_HIGH   (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .read_next (read_next),
        .stop_data (stop_data),
        .data_ready(data_ready),
        .data      (data),
        .save_addr (save_addr),
        .load_addr (load_addr),
        .clear_addr(clear_addr),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_d_out (spi_d_out),
        .spi_d_oe  (spi_d_oe),
        .spi_d_in  (spi_d_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    task automatic check_min(input string nm, input int act, input int req);
        n_checks++;
        if (act >= req) n_pass++;
        else $display("FAIL %s: got %0d, required at least %0d", nm, act, req);
    endtask

    // ---------------- flash model ----------------
    function automatic logic [15:0] fword(input logic [23:0] a);
        if (a == 24'h0) return 16'hA5C3;
        return (a[15:0] * 16'h9E37) ^ {8'h3C, a[23:16]};
    endfunction

    int          bc = 0;
    int          txn_cnt = 0;
    int          bad_oe = 0;
    int          fk;
    logic [15:0] fw;
    logic [7:0]  f_cmd;
    logic [23:0] f_addr;
    logic [7:0]  last_cmd;
    logic [23:0] last_addr;

    // Counts sck rising edges inside a transaction: 8 cmd bits, 24 address
    // bits, 8 dummy periods, then nibbles of consecutive words.
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            bc = 0;
        end else begin
            if (bc < 32) begin
                if (spi_d_oe !== 4'b0001) bad_oe++;
            end else if (spi_d_oe !== 4'b0000) begin
                bad_oe++;
            end
            if (bc < 8) begin
                f_cmd = {f_cmd[6:0], spi_d_out[0]};
            end else if (bc < 32) begin
                f_addr = {f_addr[22:0], spi_d_out[0]};
                if (bc == 31) begin
                    last_cmd  = f_cmd;
                    last_addr = f_addr;
                    txn_cnt++;
                end
            end else if (bc >= 40) begin
                fk = bc - 40;
                fw = fword(f_addr + 24'(2 * (fk / 4)));
                spi_d_in = 4'(fw >> (12 - 4 * (fk % 4)));
            end
            bc++;
        end
    end

    // ---------------- reference model ----------------
    logic [23:0] m_cur;
    logic [23:0] m_saved;

    function automatic logic [23:0] next_word_addr(input logic [23:0] a);
`ifdef RLE_FETCH_WRAP_EN
        if (a == ENDA) return BASE;
`endif
        return a + 24'd2;
    endfunction

    task automatic model_apply(input bit p, input bit sv, input bit ld, input bit cl);
        logic [23:0] after_pop;
        logic [23:0] old_saved;
        after_pop = p ? next_word_addr(m_cur) : m_cur;
        old_saved = m_saved;
        if (sv) m_saved = after_pop;
        if (cl) m_cur = BASE;
        else if (ld) m_cur = old_saved;
        else m_cur = after_pop;
    endtask

    // ---------------- helpers ----------------
    task automatic pop_one(input string nm);
        int t = 0;
        while (!data_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({nm, " ready"}, data_ready, 1'b1);
        if (data_ready) begin
            check({nm, " data"}, data, fword(m_cur));
            read_next = 1'b1;
            @(negedge clk);
            read_next = 1'b0;
            model_apply(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_head(input string nm, input logic [23:0] exp_addr);
        int t = 0;
        while (!data_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({nm, " head"}, data, fword(exp_addr));
    endtask

    task automatic do_op(input bit sv, input bit ld, input bit cl, input logic [23:0] exp_txn);
        int base_txn;
        int hi = 0;
        int t = 0;
        base_txn   = txn_cnt;
        save_addr  = sv;
        load_addr  = ld;
        clear_addr = cl;
        model_apply(1'b0, sv, ld, cl);
        @(negedge clk);
        save_addr  = 1'b0;
        load_addr  = 1'b0;
        clear_addr = 1'b0;
        check("op data_ready", data_ready, 1'b0);
        check("op cs_n", spi_cs_n, 1'b1);
        while (spi_cs_n && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        check_min("op cs gap", hi, 2);
        while (txn_cnt == base_txn && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("op txn addr", last_addr, exp_txn);
        check("op txn cmd", last_cmd, 8'h6B);
    endtask

    typedef struct {
        int          pops;
        bit          sv;
        bit          ld;
        bit          cl;
        logic [23:0] exp_txn;
        logic [23:0] exp_head;
    } step_t;

    step_t tab [0:6];

    initial begin
        int k;
        int j;
        int t;
        int nsck;
        logic prev_sck;

        rstn       = 1'b0;
        read_next  = 1'b0;
        stop_data  = 1'b0;
        save_addr  = 1'b0;
        load_addr  = 1'b0;
        clear_addr = 1'b0;
        spi_d_in   = 4'h0;
        m_cur      = BASE;
        m_saved    = BASE;

        tab[0] = '{5, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h00000A};
        tab[1] = '{3, 1'b0, 1'b1, 1'b0, 24'h00000A, 24'h00000A};
        tab[2] = '{2, 1'b0, 1'b1, 1'b1, 24'h000000, 24'h000000};
        tab[3] = '{4, 1'b0, 1'b1, 1'b0, 24'h00000A, 24'h00000A};
        tab[4] = '{3, 1'b1, 1'b1, 1'b0, 24'h00000A, 24'h00000A};
        tab[5] = '{0, 1'b0, 1'b1, 1'b0, 24'h000010, 24'h000010};
        tab[6] = '{1, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000};

        // ---- reset state and first fetch ----
        repeat (3) @(negedge clk);
        check("rst cs_n", spi_cs_n, 1'b1);
        check("rst sck", spi_sck, 1'b0);
        check("rst oe", spi_d_oe, 4'h0);
        check("rst dout", spi_d_out, 4'h0);
        check("rst data_ready", data_ready, 1'b0);
        rstn = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (spi_cs_n && k < 20);
        check("cs fall delay", k, 2);
        j = 0;
        while (!data_ready && j < 200) begin
            @(negedge clk);
            j++;
        end
        check("first data latency", j, 89);
        check("first cmd", last_cmd, 8'h6B);
        check("first addr", last_addr, 24'h000000);
        check("first word", data, 16'hA5C3);

`ifdef RLE_FETCH_WRAP_EN
        // ---- wrap: words 0,2,4,6 then a new transaction at BASE ----
        for (int i = 0; i < 6; i++) pop_one("wrap pop");
        t = 0;
        while (txn_cnt < 2 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_min("wrap txn count", txn_cnt, 2);
        check("wrap txn addr", last_addr, 24'h000000);
`else
        // ---- table-driven address operations ----
        for (int i = 0; i < 7; i++) begin
            for (int p = 0; p < tab[i].pops; p++) pop_one("tab pop");
            if (tab[i].ld | tab[i].cl) begin
                do_op(tab[i].sv, tab[i].ld, tab[i].cl, tab[i].exp_txn);
            end else begin
                save_addr = tab[i].sv;
                model_apply(1'b0, tab[i].sv, 1'b0, 1'b0);
                @(negedge clk);
                save_addr = 1'b0;
            end
            wait_head("tab", tab[i].exp_head);
        end

        // ---- backpressure: no reads for 200 clk ----
        repeat (100) @(negedge clk);
        nsck = 0;
        prev_sck = spi_sck;
        repeat (100) begin
            @(negedge clk);
            if (spi_sck != prev_sck) nsck++;
            prev_sck = spi_sck;
        end
        check("pause sck toggles", nsck, 0);
        check("pause sck low", spi_sck, 1'b0);
        check("pause cs low", spi_cs_n, 1'b0);
        pop_one("pause pop0");
        check("second word held", data_ready, 1'b1);
        for (int i = 0; i < 4; i++) pop_one("resume pop");

        // ---- stop_data mid-word ----
        t = 0;
        while (!(spi_sck && !spi_cs_n && bc >= 40 && ((bc - 40) % 4) == 2) && t < 500) begin
            @(negedge clk);
            t++;
        end
        stop_data = 1'b1;
        @(negedge clk);
        check("stop data_ready", data_ready, 1'b0);
        check("stop cs_n", spi_cs_n, 1'b1);
        repeat (9) @(negedge clk);
        check("stop held cs_n", spi_cs_n, 1'b1);
        k = txn_cnt;
        stop_data = 1'b0;
        t = 0;
        while (txn_cnt == k && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("stop restart addr", last_addr, m_cur);
        pop_one("stop resume");

        // ---- read_next on empty FIFO ----
        do_op(1'b0, 1'b0, 1'b1, 24'h000000);
        read_next = 1'b1;
        repeat (8) @(negedge clk);
        check("empty read ready", data_ready, 1'b0);
        read_next = 1'b0;
        wait_head("empty read", 24'h000000);
`endif

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 4000; c++) begin
            int r;
            int rdprob;
            bit rd;
            bit sv;
            bit ld;
            bit cl;
            bit p;
            r      = $urandom_range(0, 999);
            rdprob = ((c / 500) % 2) ? 90 : 15;
            rd     = ($urandom_range(0, 99) < rdprob);
            sv     = (r < 8);
            ld     = (r >= 8 && r < 14);
            cl     = (r >= 14 && r < 18);
            if (r >= 18 && r < 22) begin
                stop_data = 1'b1;
                @(negedge clk);
                check("rnd stop data_ready", data_ready, 1'b0);
                repeat ($urandom_range(0, 7)) @(negedge clk);
                stop_data = 1'b0;
            end else begin
                p = rd && data_ready;
                if (p) check("rnd data", data, fword(m_cur));
                read_next  = rd;
                save_addr  = sv;
                load_addr  = ld;
                clear_addr = cl;
                model_apply(p, sv, ld, cl);
                @(negedge clk);
                read_next  = 1'b0;
                save_addr  = 1'b0;
                load_addr  = 1'b0;
                clear_addr = 1'b0;
            end
        end

        // ---- reset in the middle of a transaction ----
        t = 0;
        while (spi_cs_n && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst cs_n", spi_cs_n, 1'b1);
        check("midrst data_ready", data_ready, 1'b0);
        check("midrst sck", spi_sck, 1'b0);
        rstn = 1'b1;
        m_cur   = BASE;
        m_saved = BASE;
        pop_one("after midrst");

        check("oe pattern errors", bad_oe, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
